// File: rtl/slp_pkg.sv
// slp_pkg
// Shared definitions for the single-layer-perceptron weight-update engine:
//   - state_t      : sequencer FSM states
//   - frac_bits()  : fractional bit count of a two's complement fixed-point format
//   - MODE_*       : learning-rule encodings carried on the `mode` input
package slp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_PERCEP  = 1'b0;
  localparam logic MODE_ADALINE = 1'b1;

  // One bit is the sign and `exp` bits are integer bits; the rest are fraction.
  function automatic int frac_bits(input int prec, input int exp);
    return prec - 1 - exp;
  endfunction

endpackage

// File: rtl/slp_weight_seq_if.sv
// slp_weight_seq_if
// Bundles the control, load and weight-file signals of slp_weight_seq.
//   master : the controller side (drives start/mode/rate/error/in_data and the load port)
//   slave  : the engine side (drives busy/done/sat/weights)
// Signals:
//   start, mode, rate, error, in_data : update-pass request and its operands
//   w_we, w_idx, w_wdata              : single-weight load port
//   busy, done, sat, weights          : pass status and the packed weight file
interface slp_weight_seq_if #(
  parameter int N_IN   = 8,
  parameter int I_PREC = 8,
  parameter int R_PREC = 8,
  parameter int W_PREC = 16,
  parameter int F_PREC = 8
);
  localparam int IDX_W = $clog2(N_IN);

  logic                     start;
  logic                     mode;
  logic [R_PREC-1:0]        rate;
  logic [F_PREC-1:0]        error;
  logic [N_IN*I_PREC-1:0]   in_data;
  logic                     w_we;
  logic [IDX_W-1:0]         w_idx;
  logic [W_PREC-1:0]        w_wdata;
  logic                     busy;
  logic                     done;
  logic                     sat;
  logic [N_IN*W_PREC-1:0]   weights;

  modport master (
    output start, mode, rate, error, in_data, w_we, w_idx, w_wdata,
    input  busy, done, sat, weights
  );

  modport slave (
    input  start, mode, rate, error, in_data, w_we, w_idx, w_wdata,
    output busy, done, sat, weights
  );

endinterface

// File: rtl/slp_fx_mulsat.sv
// slp_fx_mulsat
// Combinational signed fixed-point multiply, realign and saturate.
//   a   : A_PREC-bit operand with A_FRAC fractional bits
//   b   : B_PREC-bit operand with B_FRAC fractional bits
//   y   : product realigned to O_FRAC fractional bits, clamped to O_PREC bits
//   sat : high when the clamp was applied
// Dropping fractional bits uses an arithmetic right shift, so rounding is floor.
module slp_fx_mulsat #(
  parameter int A_PREC = 8,
  parameter int A_FRAC = 4,
  parameter int B_PREC = 8,
  parameter int B_FRAC = 4,
  parameter int O_PREC = 16,
  parameter int O_FRAC = 11
) (
  input  logic signed [A_PREC-1:0] a,
  input  logic signed [B_PREC-1:0] b,
  output logic signed [O_PREC-1:0] y,
  output logic                     sat
);

  localparam int P_PREC = A_PREC + B_PREC;
  localparam int P_FRAC = A_FRAC + B_FRAC;
  localparam int L_SH   = (O_FRAC > P_FRAC) ? (O_FRAC - P_FRAC) : 0;
  localparam int R_SH   = (P_FRAC > O_FRAC) ? (P_FRAC - O_FRAC) : 0;
  localparam int X_PREC = P_PREC + L_SH;

  localparam logic signed [O_PREC-1:0] O_MAX = {1'b0, {(O_PREC-1){1'b1}}};
  localparam logic signed [O_PREC-1:0] O_MIN = {1'b1, {(O_PREC-1){1'b0}}};

  logic signed [P_PREC-1:0] prod;
  logic signed [X_PREC-1:0] aligned;

  assign prod = P_PREC'(a) * P_PREC'(b);

  // At most one of the two shifts is non-zero; the left shift widens the
  // word so no product bits are lost before the range check.
  assign aligned = (X_PREC'(prod) <<< L_SH) >>> R_SH;

  generate
    if (X_PREC > O_PREC) begin : g_clamp
      // The value fits only if every bit above the output sign bit equals it.
      logic [X_PREC-O_PREC:0] head;
      assign head = aligned[X_PREC-1:O_PREC-1];

      always_comb begin
        sat = 1'b0;
        y   = aligned[O_PREC-1:0];
        if (!((&head) || !(|head))) begin
          sat = 1'b1;
          y   = aligned[X_PREC-1] ? O_MIN : O_MAX;
        end
      end
    end else begin : g_fit
      assign y   = O_PREC'(aligned);
      assign sat = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/slp_weight_seq.sv
// slp_weight_seq
// Sequential weight-update engine for the single-layer perceptron. One start
// applies a learning step to all N_IN weights, one channel per cycle, through
// a two-stage pipeline (delta register, then saturating accumulate).
//   clk, reset_ : clock and asynchronous active-low reset
//   bus         : slp_weight_seq_if slave port
//                 start/mode/rate/error/in_data sampled when start is accepted
//                 w_we/w_idx/w_wdata load a single weight while idle
//                 busy/done/sat status, weights = packed registered weight file
module slp_weight_seq
  import slp_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int I_PREC = 8,
  parameter int I_EXP  = 3,
  parameter int R_PREC = 8,
  parameter int R_EXP  = 0,
  parameter int W_PREC = 16,
  parameter int W_EXP  = 4,
  parameter int F_PREC = 8,
  parameter int F_EXP  = 3
) (
  input logic           clk,
  input logic           reset_,
  slp_weight_seq_if.slave bus
);

  localparam int IDX_W   = $clog2(N_IN);
  localparam int I_FRAC  = frac_bits(I_PREC, I_EXP);
  localparam int R_FRAC  = frac_bits(R_PREC, R_EXP);
  localparam int W_FRAC  = frac_bits(W_PREC, W_EXP);
  localparam int F_FRAC  = frac_bits(F_PREC, F_EXP);
  localparam int P1_PREC = I_PREC + F_PREC;
  localparam int P1_FRAC = I_FRAC + F_FRAC;
  localparam int RB      = R_PREC + 1;

  // Unity in the widened rate format; lets Perceptron share the rate multiplier.
  localparam logic signed [RB-1:0]     RATE_ONE = RB'(1) << R_FRAC;
  localparam logic signed [W_PREC-1:0] W_MAX    = {1'b0, {(W_PREC-1){1'b1}}};
  localparam logic signed [W_PREC-1:0] W_MIN    = {1'b1, {(W_PREC-1){1'b0}}};

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx;

  logic                      mode_q;
  logic signed [R_PREC-1:0]  rate_q;
  logic signed [F_PREC-1:0]  error_q;
  logic [N_IN*I_PREC-1:0]    in_q;

  logic signed [W_PREC-1:0]  weight_q [N_IN];
  logic                      sat_q;

  logic                      s1_valid;
  logic [IDX_W-1:0]          s1_idx;
  logic signed [W_PREC-1:0]  delta_q;

  logic                      start_ok;
  logic                      load_ok;
  logic                      issue;

  logic signed [I_PREC-1:0]  in_sel;
  logic signed [P1_PREC-1:0] p1;
  logic signed [RB-1:0]      rate_eff;
  logic signed [W_PREC-1:0]  delta_c;
  logic                      sat_m1;
  logic                      sat_m2;

  logic signed [W_PREC-1:0]  w_cur;
  logic signed [W_PREC:0]    sum_full;
  logic signed [W_PREC-1:0]  sum_sat;
  logic                      sat_add;

  assign start_ok = (state == IDLE) && bus.start;
  // Loads are only taken in IDLE, which also keeps them clear of stage-2 writes.
  assign load_ok  = (state == IDLE) && bus.w_we && (32'(bus.w_idx) < N_IN);
  assign issue    = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (idx == IDX_W'(N_IN - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      idx     <= '0;
      mode_q  <= MODE_PERCEP;
      rate_q  <= '0;
      error_q <= '0;
      in_q    <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        idx     <= '0;
        mode_q  <= bus.mode;
        rate_q  <= bus.rate;
        error_q <= bus.error;
        in_q    <= bus.in_data;
      end else if (issue) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Stage 1: in*error at full precision, then scaled by rate (or unity) and
  // realigned/clamped to the weight format.
  assign in_sel   = in_q[int'(idx)*I_PREC +: I_PREC];
  assign rate_eff = (mode_q == MODE_ADALINE) ? {rate_q[R_PREC-1], rate_q} : RATE_ONE;

  slp_fx_mulsat #(
    .A_PREC(I_PREC),  .A_FRAC(I_FRAC),
    .B_PREC(F_PREC),  .B_FRAC(F_FRAC),
    .O_PREC(P1_PREC), .O_FRAC(P1_FRAC)
  ) u_mul_err (
    .a   (in_sel),
    .b   (error_q),
    .y   (p1),
    .sat (sat_m1)
  );

  slp_fx_mulsat #(
    .A_PREC(P1_PREC), .A_FRAC(P1_FRAC),
    .B_PREC(RB),      .B_FRAC(R_FRAC),
    .O_PREC(W_PREC),  .O_FRAC(W_FRAC)
  ) u_mul_rate (
    .a   (p1),
    .b   (rate_eff),
    .y   (delta_c),
    .sat (sat_m2)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      delta_q  <= '0;
    end else begin
      s1_valid <= issue;
      s1_idx   <= idx;
      delta_q  <= delta_c;
    end
  end

  // Stage 2: saturating accumulate; overflow shows as disagreeing top two bits.
  assign w_cur    = weight_q[s1_idx];
  assign sum_full = {w_cur[W_PREC-1], w_cur} + {delta_q[W_PREC-1], delta_q};

  always_comb begin
    sat_add = (sum_full[W_PREC] != sum_full[W_PREC-1]);
    sum_sat = sum_full[W_PREC-1:0];
    if (sat_add) sum_sat = sum_full[W_PREC] ? W_MIN : W_MAX;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= '0;
      sat_q <= 1'b0;
    end else begin
      if (load_ok)  weight_q[bus.w_idx] <= bus.w_wdata;
      if (s1_valid) weight_q[s1_idx]    <= sum_sat;
      if (start_ok)
        sat_q <= 1'b0;
      else if ((issue && (sat_m1 || sat_m2)) || (s1_valid && sat_add))
        sat_q <= 1'b1;
    end
  end

  always_comb begin
    bus.weights = '0;
    for (int i = 0; i < N_IN; i++) bus.weights[i*W_PREC +: W_PREC] = weight_q[i];
  end

  assign bus.busy = (state == RUN) || (state == DRAIN);
  assign bus.done = (state == DONE);
  assign bus.sat  = sat_q;

endmodule

// File: tb/tb_slp_weight_seq.sv
// tb_slp_weight_seq
// Directed bench for slp_weight_seq. Each accepted pass pushes its expected
// weight file, sat flag and done cycle into a queue; a monitor pops and
// compares whenever the engine pulses done.
module tb_slp_weight_seq;

  localparam int N_IN   = 8;
  localparam int I_PREC = 8;
  localparam int R_PREC = 8;
  localparam int W_PREC = 16;
  localparam int F_PREC = 8;

  typedef struct {
    logic [N_IN*W_PREC-1:0] weights;
    logic                   sat;
    int                     done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_w [N_IN];

  slp_weight_seq_if #(
    .N_IN(N_IN), .I_PREC(I_PREC), .R_PREC(R_PREC), .W_PREC(W_PREC), .F_PREC(F_PREC)
  ) bus ();

  slp_weight_seq #(
    .N_IN(N_IN), .I_PREC(I_PREC), .I_EXP(3), .R_PREC(R_PREC), .R_EXP(0),
    .W_PREC(W_PREC), .W_EXP(4), .F_PREC(F_PREC), .F_EXP(3)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  function automatic logic [N_IN*W_PREC-1:0] pack_exp();
    logic [N_IN*W_PREC-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*W_PREC +: W_PREC] = exp_w[i];
    return v;
  endfunction

  function automatic logic [N_IN*I_PREC-1:0] mk_in(input int ch, input logic [7:0] val);
    logic [N_IN*I_PREC-1:0] v;
    v = '0;
    v[ch*I_PREC +: I_PREC] = val;
    return v;
  endfunction

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_weight(input logic [2:0] idx, input logic [15:0] val);
    bus.w_we    = 1'b1;
    bus.w_idx   = idx;
    bus.w_wdata = val;
    @(negedge clk);
    bus.w_we    = 1'b0;
  endtask

  // Called at a negedge; start is high for exactly that cycle, reported as t.
  task automatic issue_start(input logic m, input logic [7:0] r, input logic [7:0] e,
                             input logic [N_IN*I_PREC-1:0] din, input logic we,
                             input logic [2:0] widx, input logic [15:0] wd, output int t);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.rate    = r;
    bus.error   = e;
    bus.in_data = din;
    bus.w_we    = we;
    bus.w_idx   = widx;
    bus.w_wdata = wd;
    t = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.w_we  = 1'b0;
  endtask

  // Expected weights must already be in exp_w; returns at the earliest next-start cycle.
  task automatic apply_stimulus(input logic m, input logic [7:0] r, input logic [7:0] e,
                                input logic [N_IN*I_PREC-1:0] din, input logic exp_sat,
                                input logic we, input logic [2:0] widx, input logic [15:0] wd);
    int t;
    exp_t x;
    issue_start(m, r, e, din, we, widx, wd, t);
    x.weights  = pack_exp();
    x.sat      = exp_sat;
    x.done_cyc = t + N_IN + 2;
    sb.push_back(x);
    wait_cycle(t + N_IN + 3);
  endtask

  always @(negedge clk) begin
    if (reset_ === 1'b1 && bus.done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done cycle=%0d actual=1 expected=0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check_output("pass_weights", bus.weights, mon_e.weights);
        check_output("pass_sat", 128'(bus.sat), 128'(mon_e.sat));
        check_output("done_cycle", 128'(cyc), 128'(mon_e.done_cyc));
        check_output("busy_at_done", 128'(bus.busy), 128'(0));
      end
    end
  end

  initial begin
    int t;
    int dc;
    reset_      = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.rate    = '0;
    bus.error   = '0;
    bus.in_data = '0;
    bus.w_we    = 1'b0;
    bus.w_idx   = '0;
    bus.w_wdata = '0;
    for (int i = 0; i < N_IN; i++) exp_w[i] = 16'h0000;

    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    check_output("reset_busy", 128'(bus.busy), 128'(0));
    check_output("reset_done", 128'(bus.done), 128'(0));
    check_output("reset_sat", 128'(bus.sat), 128'(0));
    check_output("reset_weights", bus.weights, 128'(0));

    // Load a weight, start a pass, then abort it with reset mid-RUN.
    load_weight(3'd5, 16'h1234);
    check_output("load_visible", 128'(bus.weights[5*W_PREC +: W_PREC]), 128'(16'h1234));
    issue_start(1'b0, 8'h00, 8'h10, mk_in(5, 8'h10), 1'b0, 3'd0, 16'h0, t);
    wait_cycle(t + 4);
    dc = done_count;
    reset_ = 1'b0;
    @(negedge clk);
    check_output("abort_weights", bus.weights, 128'(0));
    check_output("abort_busy", 128'(bus.busy), 128'(0));
    check_output("abort_done", 128'(bus.done), 128'(0));
    reset_ = 1'b1;
    repeat (N_IN + 4) @(negedge clk);
    check_output("abort_no_done", 128'(done_count), 128'(dc));

    // Perceptron: 1.0 * 0.5 -> +0.5 = 0x0400.
    exp_w[0] = 16'h0400;
    apply_stimulus(1'b0, 8'h00, 8'h08, mk_in(0, 8'h10), 1'b0, 1'b0, 3'd0, 16'h0);

    // Adaline: 0x0800 + 0.5 * 1.0 * 1.0 = 0x0C00.
    load_weight(3'd3, 16'h0800);
    exp_w[3] = 16'h0C00;
    apply_stimulus(1'b1, 8'h40, 8'h10, mk_in(3, 8'h10), 1'b0, 1'b0, 3'd0, 16'h0);

    // Saturation: delta clamps to 0x7FFF, sum clamps to 0x7FFF.
    load_weight(3'd1, 16'h7F00);
    exp_w[1] = 16'h7FFF;
    apply_stimulus(1'b0, 8'h00, 8'h7F, mk_in(1, 8'h7F), 1'b1, 1'b0, 3'd0, 16'h0);

    // error = 0: nothing moves, sat is cleared by the new start.
    apply_stimulus(1'b0, 8'h00, 8'h00, {N_IN{8'h7F}}, 1'b0, 1'b0, 3'd0, 16'h0);

    // Negative update: 0x0400 + (-1.0 * 0.5) = 0.
    load_weight(3'd2, 16'h0400);
    exp_w[2] = 16'h0000;
    apply_stimulus(1'b0, 8'h00, 8'h08, mk_in(2, 8'hF0), 1'b0, 1'b0, 3'd0, 16'h0);

    // Protocol: stray start and loads while busy or in DONE are ignored.
    exp_w[4] = 16'h0800;
    issue_start(1'b0, 8'h00, 8'h10, mk_in(4, 8'h10), 1'b0, 3'd0, 16'h0, t);
    begin
      exp_t x;
      x.weights  = pack_exp();
      x.sat      = 1'b0;
      x.done_cyc = t + N_IN + 2;
      sb.push_back(x);
    end
    wait_cycle(t + 3);
    bus.start   = 1'b1;
    bus.mode    = 1'b1;
    bus.rate    = 8'h7F;
    bus.error   = 8'h7F;
    bus.in_data = {N_IN{8'h7F}};
    @(negedge clk);
    bus.start = 1'b0;
    load_weight(3'd0, 16'h5555);
    wait_cycle(t + N_IN + 2);
    load_weight(3'd6, 16'h1111);
    check_output("busy_load_ignored", bus.weights, pack_exp());

    // Load and start together: 0x0100 is loaded, then 1.0 * 0.5 is added.
    exp_w[7] = 16'h0500;
    apply_stimulus(1'b0, 8'h00, 8'h08, mk_in(7, 8'h10), 1'b0, 1'b1, 3'd7, 16'h0100);

    repeat (4) @(negedge clk);
    check_output("scoreboard_drained", 128'(sb.size()), 128'(0));
    check_output("done_total", 128'(done_count), 128'(7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
